// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter; the master drives the controls and reads the count.
// With CNT_CMP_EN defined the bundle also carries the compare value CMP and the MATCH flag.
interface mod_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             SCLRn;
  logic             LDn;
  logic             ENP;
  logic             ENT;
  logic             UP;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             RCO;
  logic             WRAP;
`ifdef CNT_CMP_EN
  logic [WIDTH-1:0] CMP;
  logic             MATCH;

  modport master (output SCLRn, LDn, ENP, ENT, UP, D, CMP,
                  input  Q, RCO, WRAP, MATCH);
  modport slave  (input  SCLRn, LDn, ENP, ENT, UP, D, CMP,
                  output Q, RCO, WRAP, MATCH);
`else
  modport master (output SCLRn, LDn, ENP, ENT, UP, D,
                  input  Q, RCO, WRAP);
  modport slave  (input  SCLRn, LDn, ENP, ENT, UP, D,
                  output Q, RCO, WRAP);
`endif
endinterface

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with clear, load, ENP/ENT cascade enables, RCO and a WRAP pulse.
// Optional compare output MATCH is built only when CNT_CMP_EN is defined.
module mod_updown_counter #(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MODULUS = longint'(1) << WIDTH,
  parameter int unsigned     RST_VAL = 0
) (
  input  logic                  CLK,
  input  logic                  CLR,
  mod_updown_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - longint'(1));
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;
  logic             w_term;
  logic             w_step;

  // Out-of-range values (after a load) fold back to 0 going up and to MAX going down.
  function automatic logic [WIDTH-1:0] f_step_up(input logic [WIDTH-1:0] q);
    return (q >= MAX) ? '0 : q + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] f_step_dn(input logic [WIDTH-1:0] q);
    if (q == '0)       return MAX;
    else if (q > MAX)  return MAX;
    else               return q - WIDTH'(1);
  endfunction

  assign w_term = bus.UP ? (r_q == MAX) : (r_q == '0);
  assign w_step = bus.ENP & bus.ENT;

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (!bus.SCLRn) begin
      w_q_nxt = '0;
    end else if (!bus.LDn) begin
      w_q_nxt = bus.D;
    end else if (w_step) begin
      w_wrap_nxt = w_term;
      w_q_nxt    = bus.UP ? f_step_up(r_q) : f_step_dn(r_q);
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_q    <= RST_Q;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign bus.Q    = r_q;
  assign bus.WRAP = r_wrap;
  // RCO is gated only by ENT so that a cascade's carry ripples combinationally in one cycle.
  assign bus.RCO  = w_term & bus.ENT;

`ifdef CNT_CMP_EN
  logic r_match;

  // Compares against the value Q is about to take, so MATCH lines up with Q.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) r_match <= 1'b0;
    else     r_match <= (w_q_nxt == bus.CMP);
  end

  assign bus.MATCH = r_match;
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: decade counter, 5-bit counter with nonzero reset value, and an 8-bit cascade of two 4-bit stages.
module tb_mod_updown_counter;

  logic CLK = 1'b0;
  logic CLR;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  mod_updown_counter_if #(.WIDTH(4)) ia ();
  mod_updown_counter_if #(.WIDTH(5)) ic ();
  mod_updown_counter_if #(.WIDTH(4)) il ();
  mod_updown_counter_if #(.WIDTH(4)) ih ();

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_a  (.CLK(CLK), .CLR(CLR), .bus(ia));
  mod_updown_counter #(.WIDTH(5), .RST_VAL(7))               u_c  (.CLK(CLK), .CLR(CLR), .bus(ic));
  mod_updown_counter #(.WIDTH(4))                            u_lo (.CLK(CLK), .CLR(CLR), .bus(il));
  mod_updown_counter #(.WIDTH(4))                            u_hi (.CLK(CLK), .CLR(CLR), .bus(ih));

  assign ih.ENT = il.RCO;

  // Reference model: plain integers following the counting rules.
  int ma_q = 0, mc_q = 7, mcas = 0;
  bit ma_w = 0, mc_w = 0, ml_w = 0, mh_w = 0;
  bit ma_m = 0, mc_m = 0;

  function automatic int f_next(input int q, input int m, input bit up);
    if (up) return (q >= m - 1) ? 0 : q + 1;
    if (q == 0) return m - 1;
    if (q > m - 1) return m - 1;
    return q - 1;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      ma_q = 0; mc_q = 7; mcas = 0;
      ma_w = 0; mc_w = 0; ml_w = 0; mh_w = 0; ma_m = 0; mc_m = 0;
    end else begin
      ma_w = 0;
      if (!ia.SCLRn)     ma_q = 0;
      else if (!ia.LDn)  ma_q = int'(ia.D);
      else if (ia.ENP && ia.ENT) begin
        ma_w = ia.UP ? (ma_q == 9) : (ma_q == 0);
        ma_q = f_next(ma_q, 10, ia.UP);
      end
      mc_w = 0;
      if (!ic.SCLRn)     mc_q = 0;
      else if (!ic.LDn)  mc_q = int'(ic.D);
      else if (ic.ENP && ic.ENT) begin
        mc_w = ic.UP ? (mc_q == 31) : (mc_q == 0);
        mc_q = f_next(mc_q, 32, ic.UP);
      end
      ml_w = 0; mh_w = 0;
      if (!il.SCLRn)     mcas = 0;
      else if (!il.LDn)  mcas = int'(ih.D) * 16 + int'(il.D);
      else if (il.ENP) begin
        ml_w = il.UP ? (mcas % 16 == 15) : (mcas % 16 == 0);
        mh_w = il.UP ? (mcas == 255) : (mcas == 0);
        mcas = il.UP ? (mcas + 1) % 256 : (mcas + 255) % 256;
      end
`ifdef CNT_CMP_EN
      ma_m = (ma_q == int'(ia.CMP));
      mc_m = (mc_q == int'(ic.CMP));
`endif
    end
  end

  always @(negedge CLK) begin
    chk("a_q",      ia.Q, ma_q);
    chk("a_wrap",   ia.WRAP, ma_w);
    chk("a_rco",    ia.RCO, ia.ENT && (ia.UP ? ma_q == 9 : ma_q == 0));
    chk("c_q",      ic.Q, mc_q);
    chk("c_wrap",   ic.WRAP, mc_w);
    chk("c_rco",    ic.RCO, ic.ENT && (ic.UP ? mc_q == 31 : mc_q == 0));
    chk("cas_q",    {ih.Q, il.Q}, mcas);
    chk("cas_lo_w", il.WRAP, ml_w);
    chk("cas_hi_w", ih.WRAP, mh_w);
    chk("cas_rco",  ih.RCO, il.UP ? mcas == 255 : mcas == 0);
`ifdef CNT_CMP_EN
    chk("a_match",  ia.MATCH, ma_m);
    chk("c_match",  ic.MATCH, mc_m);
`endif
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic cas_ctl(input bit sclrn, input bit ldn, input bit enp, input bit up, input logic [7:0] d);
    il.SCLRn = sclrn; ih.SCLRn = sclrn;
    il.LDn   = ldn;   ih.LDn   = ldn;
    il.ENP   = enp;   ih.ENP   = enp;
    il.UP    = up;    ih.UP    = up;
    il.D     = d[3:0];
    ih.D     = d[7:4];
  endtask

  initial begin
    CLR = 1'b1;
    ia.SCLRn = 1; ia.LDn = 1; ia.ENP = 1; ia.ENT = 1; ia.UP = 1; ia.D = '0;
    ic.SCLRn = 1; ic.LDn = 1; ic.ENP = 1; ic.ENT = 1; ic.UP = 1; ic.D = '0;
    il.ENT = 1;
    cas_ctl(1, 1, 0, 1, 8'h00);
`ifdef CNT_CMP_EN
    ia.CMP = 4'd3; ic.CMP = 5'd20; il.CMP = '0; ih.CMP = '0;
`endif
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_a_q", ia.Q, 0);
    chk("rst_a_wrap", ia.WRAP, 0);
    chk("rst_c_q", ic.Q, 7);
    CLR = 1'b0;

    // Decade count up, then down
    for (int i = 1; i <= 10; i++) begin
      chk("up_rco", ia.RCO, (i == 10));
      cyc();
      chk("up_q", ia.Q, i % 10);
      chk("up_wrap", ia.WRAP, (i == 10));
    end
    ia.UP = 0;
    #1 chk("dn_rco0", ia.RCO, 1);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("dn_q", ia.Q, (10 - i) % 10);
      chk("dn_wrap", ia.WRAP, (i == 1));
    end

    // Out-of-range load
    ia.LDn = 0; ia.D = 4'd13;
    cyc(); chk("ld13_q", ia.Q, 13); chk("ld13_wrap", ia.WRAP, 0);
    ia.LDn = 1; ia.UP = 1;
    cyc(); chk("ld13_up_q", ia.Q, 0); chk("ld13_up_wrap", ia.WRAP, 0);
    ia.LDn = 0;
    cyc(); chk("ld13b_q", ia.Q, 13);
    ia.LDn = 1; ia.UP = 0;
    cyc(); chk("ld13_dn_q", ia.Q, 9);

    // Clear beats load; load beats count
    ia.SCLRn = 0; ia.LDn = 0; ia.D = 4'd5;
    cyc(); chk("clr_wins_q", ia.Q, 0);
    ia.SCLRn = 1; ia.D = 4'd9;
    cyc(); chk("ld9_q", ia.Q, 9);
    ia.UP = 1; ia.D = 4'd5;
    cyc(); chk("ld_wins_q", ia.Q, 5); chk("ld_wins_wrap", ia.WRAP, 0);

    // Async clear cuts a WRAP pulse
    ia.D = 4'd9;
    cyc();
    ia.LDn = 1;
    cyc(); chk("pre_clr_wrap", ia.WRAP, 1); chk("pre_clr_q", ia.Q, 0);
    ic.LDn = 0; ic.D = 5'd5;
    cyc();
    ic.LDn = 1;
    cyc(); chk("c_pre_clr_q", ic.Q, 6);
    #1 CLR = 1'b1;
    #1 chk("clr_async_a_q", ia.Q, 0); chk("clr_async_a_wrap", ia.WRAP, 0); chk("clr_async_c_q", ic.Q, 7);
    #1 CLR = 1'b0;

    // Cascade carries
    cas_ctl(1, 0, 0, 1, 8'h0F);
    cyc(); chk("cas_ld0f", {ih.Q, il.Q}, 8'h0F);
    cas_ctl(1, 1, 1, 1, 8'h00);
    cyc(); chk("cas_10", {ih.Q, il.Q}, 8'h10);
    cas_ctl(1, 0, 0, 1, 8'hFF);
    cyc(); chk("cas_ldff", {ih.Q, il.Q}, 8'hFF);
    cas_ctl(1, 1, 1, 1, 8'h00);
    cyc(); chk("cas_00", {ih.Q, il.Q}, 8'h00); chk("cas_hi_wrap", ih.WRAP, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      ia.SCLRn = ($urandom % 12) != 0;
      ia.LDn   = ($urandom % 6) != 0;
      ia.ENP   = ($urandom % 4) != 0;
      ia.ENT   = ($urandom % 4) != 0;
      if ($urandom % 8 == 0) ia.UP = ~ia.UP;
      ia.D     = 4'($urandom);
      ic.SCLRn = ($urandom % 12) != 0;
      ic.LDn   = ($urandom % 8) != 0;
      ic.ENP   = ($urandom % 4) != 0;
      ic.ENT   = ($urandom % 4) != 0;
      if ($urandom % 8 == 0) ic.UP = ~ic.UP;
      ic.D     = 5'($urandom);
`ifdef CNT_CMP_EN
      if ($urandom % 50 == 0) ia.CMP = 4'($urandom);
`endif
      cas_ctl(($urandom % 40) != 0, ($urandom % 20) != 0, ($urandom % 4) != 0,
              ($urandom % 16 == 0) ? ~il.UP : il.UP, 8'($urandom));
      if ($urandom % 100 == 0) begin
        #1 CLR = 1'b1;
        #1 CLR = 1'b0;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
